// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and butterfly address math for the
// 256-point radix-2 in-place DIT FFT datapath.
package fft_pkg;

  localparam int N       = 256;
  localparam int LOG2N   = 8;
  localparam int RD_LAT  = 1;                 // RAM / twiddle ROM read latency
  localparam int BF_LAT  = 3;                 // butterfly en -> vld latency
  localparam int PIPE    = RD_LAT + BF_LAT;   // read strobe -> write-back strobe

  localparam int ADDR_W  = LOG2N;             // working-RAM address width
  localparam int TW_W    = LOG2N - 1;         // twiddle ROM index width
  localparam int K_W     = LOG2N - 1;         // butterfly counter width
  localparam int STAGE_W = $clog2(LOG2N);     // stage index width
  localparam int DRAIN_W = $clog2(PIPE);      // drain counter width
  localparam int BFLY    = N / 2;             // butterflies per stage

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] p;
    logic [ADDR_W-1:0] q;
    logic [TW_W-1:0]   tw;
  } bf_addr_t;

  // Butterfly k of stage s: split k into group/position, insert a zero at
  // bit s to form p, set that bit for q, and scale position into the ROM.
  function automatic bf_addr_t bf_addr(input logic [STAGE_W-1:0] s,
                                       input logic [K_W-1:0]     k);
    logic [ADDR_W-1:0] k_w, half, pos, grp;
    bf_addr_t          a;
    k_w  = ADDR_W'(k);
    half = ADDR_W'(1) << s;
    pos  = k_w & (half - 1'b1);
    grp  = k_w >> s;
    a.p  = (grp << ({1'b0, s} + 4'd1)) | pos;
    a.q  = a.p + half;
    a.tw = TW_W'(pos << (STAGE_W'(LOG2N - 1) - s));
    return a;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register used to align strobes and addresses with the
// RAM read latency and the butterfly pipeline.
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift one tap per cycle; every tap clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a handful of flops carrying strobes, not a RAM,
      // so it is reset; a stale write strobe after reset would corrupt data.
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every tap sample the old value
      // of its neighbour, giving a true shift instead of a fall-through.
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/fft_addr_gen.sv
// Stage/butterfly sequencer for the in-place FFT: issues read addresses and
// twiddle index, then delays the strobe to drive butterfly enable and
// write-back.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr_p,
  output logic [ADDR_W-1:0]  rd_addr_q,
  output logic [TW_W-1:0]    tw_addr,
  output logic               bf_en,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr_p,
  output logic [ADDR_W-1:0]  wr_addr_q
);

  localparam logic [K_W-1:0]     K_LAST     = K_W'(BFLY - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE - 1);
  localparam int                 WB_W       = 1 + 2 * ADDR_W;

  state_t             state, state_nxt;
  logic [STAGE_W-1:0] stage_q, stage_nxt;
  logic [K_W-1:0]     k, k_nxt;
  logic [DRAIN_W-1:0] drain, drain_nxt;
  logic               armed;          // blocks a start coincident with reset release
  bf_addr_t           addr_nxt;
  logic [WB_W-1:0]    wb_out;

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    stage_nxt = stage_q;
    k_nxt     = k;
    drain_nxt = drain;
    unique case (state)
      IDLE: begin
        if (start && armed) begin
          state_nxt = RUN;
          stage_nxt = '0;
          k_nxt     = '0;
        end
      end
      RUN: begin
        k_nxt = k + 1'b1;             // wraps to 0 after the last butterfly
        if (k == K_LAST) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end
      end
      DRAIN: begin
        drain_nxt = drain + 1'b1;
        if (drain == DRAIN_LAST) begin
          drain_nxt = '0;
          if (stage_q == STAGE_LAST) begin
            state_nxt = DONE;
          end else begin
            stage_nxt = stage_q + 1'b1;
            state_nxt = RUN;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses for the butterfly that will be read next cycle.
  assign addr_nxt = bf_addr(stage_nxt, k_nxt);

  // State, counters and registered read-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage_q   <= '0;
      k         <= '0;
      drain     <= '0;
      armed     <= 1'b0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr_p <= '0;
      rd_addr_q <= '0;
      tw_addr   <= '0;
    end else begin
      state   <= state_nxt;
      stage_q <= stage_nxt;
      k       <= k_nxt;
      drain   <= drain_nxt;
      armed   <= 1'b1;
      rd_en   <= (state_nxt == RUN);
      busy    <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done    <= (state_nxt == DONE);
      if (state_nxt == RUN) begin
        rd_addr_p <= addr_nxt.p;
        rd_addr_q <= addr_nxt.q;
        tw_addr   <= addr_nxt.tw;
      end
    end
  end

  assign stage = stage_q;

  // Butterfly enable arrives together with the RAM/ROM read data.
  fft_delay_line #(.WIDTH(1), .DEPTH(RD_LAT)) u_bf_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_en),
    .q     (bf_en)
  );

  // Write-back strobe and addresses arrive together with butterfly output.
  fft_delay_line #(.WIDTH(WB_W), .DEPTH(PIPE)) u_wb_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({rd_en, rd_addr_p, rd_addr_q}),
    .q     (wb_out)
  );

  assign {wr_en, wr_addr_p, wr_addr_q} = wb_out;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench for fft_addr_gen: scoreboard of expected reads and
// writes, cycle-accurate strobe model, reset and restart scenarios.
module tb_fft_addr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_en, bf_en, wr_en;
  logic [2:0] stage;
  logic [7:0] rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
  logic [6:0] tw_addr;
  logic [46:0] all_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] stage;
    logic [7:0] p;
    logic [7:0] q;
    logic [6:0] tw;
  } rd_t;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] q;
  } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  seen [8][256];

  fft_addr_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_p (rd_addr_p),
    .rd_addr_q (rd_addr_q),
    .tw_addr   (tw_addr),
    .bf_en     (bf_en),
    .wr_en     (wr_en),
    .wr_addr_p (wr_addr_p),
    .wr_addr_q (wr_addr_q)
  );

  assign all_out = {busy, done, stage, rd_en, rd_addr_p, rd_addr_q, tw_addr,
                    bf_en, wr_en, wr_addr_p, wr_addr_q};

  always #5 clk = ~clk;

  // Expected read strobe in cycle c of a run whose start was sampled at edge 0.
  function automatic bit exp_rd(int c);
    if (c < 1 || c > 1056) return 1'b0;
    return ((c - 1) % 132) < 128;
  endfunction

  // Expected butterfly order, built group by group rather than bit by bit.
  task automatic push_run();
    rd_q.delete();
    wr_q.delete();
    for (int s = 0; s < 8; s++) begin
      int half;
      half = 1 << s;
      for (int g = 0; g < 128 / half; g++) begin
        for (int pos = 0; pos < half; pos++) begin
          rd_t r;
          wr_t w;
          r.stage = 3'(s);
          r.p     = 8'(g * 2 * half + pos);
          r.q     = 8'(g * 2 * half + pos + half);
          r.tw    = 7'(pos * (128 / half));
          w.p     = r.p;
          w.q     = r.q;
          rd_q.push_back(r);
          wr_q.push_back(w);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = i[0];
      n_checks++;
      if (all_out !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: outputs=%h expected 0", i, all_out);
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release_idle: busy=%b rd_en=%b done=%b expected 0 0 0",
                 busy, rd_en, done);
      end
    end
  endtask

  task automatic test_start_at_release();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL start_at_release: busy=%b rd_en=%b expected 0 0", busy, rd_en);
      end
      @(negedge clk);
    end
  endtask

  // Full run with scoreboard; optionally pokes start mid-run at cycle 500.
  task automatic run_full(input bit poke_500);
    int  rd_cnt = 0, wr_cnt = 0, done_cnt = 0, last_wr0 = 0, first_rd1 = 0;
    rd_t got_r, exp_r;
    wr_t got_w, exp_w;
    foreach (seen[s, a]) seen[s][a] = 0;
    @(negedge clk);
    start = 1'b1;
    push_run();
    for (int c = 1; c <= 1057; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      n_checks++;
      if (rd_en !== exp_rd(c) || bf_en !== exp_rd(c - 1) || wr_en !== exp_rd(c - 4) ||
          busy !== (c <= 1056) || done !== (c == 1057)) begin
        n_fail++;
        $display("FAIL strobes cycle %0d: rd/bf/wr/busy/done=%b%b%b%b%b expected %b%b%b%b%b",
                 c, rd_en, bf_en, wr_en, busy, done, exp_rd(c), exp_rd(c - 1),
                 exp_rd(c - 4), (c <= 1056), (c == 1057));
      end
      if (rd_en === 1'b1) begin
        rd_cnt++;
        n_checks++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL read_underflow cycle %0d: extra read p=%0d", c, rd_addr_p);
        end else begin
          exp_r = rd_q.pop_front();
          got_r = {stage, rd_addr_p, rd_addr_q, tw_addr};
          if (got_r !== exp_r) begin
            n_fail++;
            $display("FAIL read cycle %0d: s=%0d p=%0d q=%0d tw=%0d expected s=%0d p=%0d q=%0d tw=%0d",
                     c, got_r.stage, got_r.p, got_r.q, got_r.tw,
                     exp_r.stage, exp_r.p, exp_r.q, exp_r.tw);
          end
          seen[stage][rd_addr_p]++;
          seen[stage][rd_addr_q]++;
          if (exp_r.stage == 3'd1 && first_rd1 == 0) first_rd1 = c;
        end
      end
      if (wr_en === 1'b1) begin
        wr_cnt++;
        if (wr_cnt == 128) last_wr0 = c;
        n_checks++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_underflow cycle %0d: extra write p=%0d", c, wr_addr_p);
        end else begin
          exp_w = wr_q.pop_front();
          got_w = {wr_addr_p, wr_addr_q};
          if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL write cycle %0d: p=%0d q=%0d expected p=%0d q=%0d",
                     c, got_w.p, got_w.q, exp_w.p, exp_w.q);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
      // Hand-derived spot values at the boundaries.
      if (c == 1 || c == 2 || c == 128 || c == 134 || c == 930) begin
        logic [22:0] want;
        case (c)
          1:       want = {8'd0,   8'd1,   7'd0};
          2:       want = {8'd2,   8'd3,   7'd0};
          128:     want = {8'd254, 8'd255, 7'd0};
          134:     want = {8'd1,   8'd3,   7'd64};
          default: want = {8'd5,   8'd133, 7'd5};
        endcase
        n_checks++;
        if ({rd_addr_p, rd_addr_q, tw_addr} !== want || rd_en !== 1'b1) begin
          n_fail++;
          $display("FAIL spot cycle %0d: rd_en=%b p=%0d q=%0d tw=%0d expected p=%0d q=%0d tw=%0d",
                   c, rd_en, rd_addr_p, rd_addr_q, tw_addr, want[22:15], want[14:7], want[6:0]);
        end
      end
      if (c == 129) begin
        n_checks++;
        if (rd_en !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL drain_entry: rd_en=%b busy=%b expected 0 1", rd_en, busy);
        end
      end
      if (poke_500 && c == 500) start = 1'b1;
      if (poke_500 && c == 501) start = 1'b0;
    end
    n_checks++;
    if (rd_cnt != 1024 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL totals: reads=%0d done_pulses=%0d expected 1024 1", rd_cnt, done_cnt);
    end
    n_checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftovers: reads=%0d writes=%0d expected 0 0", rd_q.size(), wr_q.size());
    end
    n_checks++;
    if (last_wr0 != 132 || first_rd1 != 133) begin
      n_fail++;
      $display("FAIL stage_hazard: last_wr0=%0d first_rd1=%0d expected 132 133",
               last_wr0, first_rd1);
    end
    for (int s = 0; s < 8; s++) begin
      int bad = 0;
      for (int a = 0; a < 256; a++) if (seen[s][a] != 1) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL coverage stage %0d: %0d addresses not read once, expected 0", s, bad);
      end
    end
  endtask

  task automatic test_mid_run_reset();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run_active: busy=%b rd_en=%b expected 1 1", busy, rd_en);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL mid_run_async_clear: outputs=%h expected 0", all_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset cycle %0d: wr_en=%b done=%b busy=%b rd_en=%b expected 0",
                 i, wr_en, done, busy, rd_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_at_release();
    run_full(1'b1);         // stage addressing, alignment, completion, ignored start
    run_full(1'b0);         // restart accepted at cycle 1058
    test_mid_run_reset();
    run_full(1'b0);         // fresh run after an aborted one
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
